// File: rtl/bcd_rtc_pkg.sv
// Shared types, digit limits and load-time validation for the BCD real-time clock.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package bcd_rtc_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hh_h;
        bcd_t hh_l;
        bcd_t mm_h;
        bcd_t mm_l;
        bcd_t ss_h;
        bcd_t ss_l;
    } bcd_time_t;

    localparam bcd_t BCD_MAX         = 4'd9;
    localparam bcd_t SEC_MAX_H       = 4'd5;
    localparam bcd_t MIN_MAX_H       = 4'd5;
    localparam bcd_t HOUR_MAX_H      = 4'd2;
    localparam bcd_t HOUR_MAX_L_AT_2 = 4'd3;

    // A loadable time is a legal 24 h BCD value; hh_h <= 9 is implied by the hour check.
    function automatic logic time_valid(input bcd_time_t t);
        logic ok;
        ok = (t.hh_l <= BCD_MAX) && (t.mm_l <= BCD_MAX) && (t.ss_l <= BCD_MAX)
          && (t.mm_h <= MIN_MAX_H) && (t.ss_h <= SEC_MAX_H)
          && ((t.hh_h < HOUR_MAX_H)
              || ((t.hh_h == HOUR_MAX_H) && (t.hh_l <= HOUR_MAX_L_AT_2)));
        return ok;
    endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD 00..59 counter used for seconds and minutes, with parallel load.
// Latency: digits update on the edge after inc/load; carry is combinational (inc at 59).
// Backpressure: none, inc and load are always accepted; load has priority over inc.
module bcd_mod60_counter
    import bcd_rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] load_h,
    input  logic [3:0] load_l,
    output logic [3:0] digit_h,
    output logic [3:0] digit_l,
    output logic       carry
);

    // Carry fires in the cycle whose increment rolls 59 over to 00.
    assign carry = inc && (digit_h == SEC_MAX_H) && (digit_l == BCD_MAX);

    // Digit registers: load first, otherwise BCD increment wrapping at 59.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_h <= '0;
            digit_l <= '0;
        end else if (load) begin
            digit_h <= load_h;
            digit_l <= load_l;
        end else if (inc) begin
            if (digit_l == BCD_MAX) begin
                digit_l <= '0;
                digit_h <= (digit_h == SEC_MAX_H) ? 4'd0 : digit_h + 4'd1;
            end else begin
                digit_l <= digit_l + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_rtc_timer.sv
// BCD HH:MM:SS real-time clock with prescaler, run/pause, validated load, 12 h view and daily alarm.
// Latency: time advances on the tick edge; sec_tick/load_err/alarm pulses appear the cycle after.
// Backpressure: none; a valid load always wins over a same-cycle tick, an invalid load is dropped.
module bcd_rtc_timer
    import bcd_rtc_pkg::*;
#(
    parameter int CLK_DIV  = 50_000_000,
    parameter bit ALARM_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_run,
    input  logic        i_load,
    input  logic [23:0] i_load_time,
    input  logic        i_alarm_en,
    input  logic [15:0] i_alarm_time,
    output logic [3:0]  o_hour_h,
    output logic [3:0]  o_hour_l,
    output logic [3:0]  o_minute_h,
    output logic [3:0]  o_minute_l,
    output logic [3:0]  o_second_h,
    output logic [3:0]  o_second_l,
    output logic [3:0]  o_disp_hour_h,
    output logic [3:0]  o_disp_hour_l,
    output logic        o_pm,
    output logic        o_sec_tick,
    output logic        o_load_err,
    output logic        o_alarm
);

    localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    bcd_time_t     load_t;
    logic          load_ok;
    logic          load_bad;
    logic [PW-1:0] presc;
    logic          tick;
    logic          advance;
    logic          sec_carry;
    logic          min_carry;
    bcd_t          hour_h;
    bcd_t          hour_l;
    bcd_t          hour_h_next;
    bcd_t          hour_l_next;
    logic [4:0]    hour_bin;
    logic [4:0]    hour_12;

    assign load_t   = bcd_time_t'(i_load_time);
    assign load_ok  = i_load && time_valid(load_t);
    assign load_bad = i_load && !time_valid(load_t);
    assign tick     = i_run && (presc == PRESC_LAST);
    // A valid load swallows the tick; an invalid load is treated as no load at all.
    assign advance  = tick && !load_ok;

    // Prescaler: restarts on valid load or tick, holds while paused.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc <= '0;
        end else if (load_ok || tick) begin
            presc <= '0;
        end else if (i_run) begin
            presc <= presc + PW'(1);
        end
    end

    bcd_mod60_counter u_seconds (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .inc     (advance),
        .load    (load_ok),
        .load_h  (load_t.ss_h),
        .load_l  (load_t.ss_l),
        .digit_h (o_second_h),
        .digit_l (o_second_l),
        .carry   (sec_carry)
    );

    bcd_mod60_counter u_minutes (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .inc     (sec_carry),
        .load    (load_ok),
        .load_h  (load_t.mm_h),
        .load_l  (load_t.mm_l),
        .digit_h (o_minute_h),
        .digit_l (o_minute_l),
        .carry   (min_carry)
    );

    // Next hour value: 23 wraps to 00, otherwise BCD increment.
    always_comb begin
        hour_h_next = hour_h;
        hour_l_next = hour_l;
        if ((hour_h == HOUR_MAX_H) && (hour_l == HOUR_MAX_L_AT_2)) begin
            hour_h_next = '0;
            hour_l_next = '0;
        end else if (hour_l == BCD_MAX) begin
            hour_h_next = hour_h + 4'd1;
            hour_l_next = '0;
        end else begin
            hour_l_next = hour_l + 4'd1;
        end
    end

    // Hour register: load first, else step on minute carry.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hour_h <= '0;
            hour_l <= '0;
        end else if (load_ok) begin
            hour_h <= load_t.hh_h;
            hour_l <= load_t.hh_l;
        end else if (min_carry) begin
            hour_h <= hour_h_next;
            hour_l <= hour_l_next;
        end
    end

    assign o_hour_h = hour_h;
    assign o_hour_l = hour_l;

    // Status pulses, one cycle after the event that caused them.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sec_tick <= 1'b0;
            o_load_err <= 1'b0;
        end else begin
            o_sec_tick <= advance;
            o_load_err <= load_bad;
        end
    end

    generate
        if (ALARM_EN) begin : g_alarm
            bcd_t mm_h_nx;
            bcd_t mm_l_nx;
            bcd_t hh_h_nx;
            bcd_t hh_l_nx;

            // hh:mm the clock is about to enter; only meaningful when seconds roll to 00.
            always_comb begin
                mm_h_nx = o_minute_h;
                mm_l_nx = o_minute_l;
                if (min_carry) begin
                    mm_h_nx = '0;
                    mm_l_nx = '0;
                end else if (o_minute_l == BCD_MAX) begin
                    mm_h_nx = o_minute_h + 4'd1;
                    mm_l_nx = '0;
                end else begin
                    mm_l_nx = o_minute_l + 4'd1;
                end
                hh_h_nx = min_carry ? hour_h_next : hour_h;
                hh_l_nx = min_carry ? hour_l_next : hour_l;
            end

            // Alarm pulse on a tick-driven entry into hh:mm:00 matching the armed time.
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    o_alarm <= 1'b0;
                end else begin
                    o_alarm <= sec_carry && i_alarm_en
                            && ({hh_h_nx, hh_l_nx, mm_h_nx, mm_l_nx} == i_alarm_time);
                end
            end
        end else begin : g_no_alarm
            assign o_alarm = 1'b0;
        end
    endgenerate

    // 12 h view: 00 shows as 12, 13..23 fold down by 12.
    assign hour_bin = (5'(hour_h) * 5'd10) + 5'(hour_l);
    always_comb begin
        hour_12 = hour_bin;
        if (hour_bin == 5'd0) begin
            hour_12 = 5'd12;
        end else if (hour_bin > 5'd12) begin
            hour_12 = hour_bin - 5'd12;
        end
    end

    assign o_disp_hour_h = (hour_12 >= 5'd10) ? 4'd1 : 4'd0;
    assign o_disp_hour_l = (hour_12 >= 5'd10) ? 4'(hour_12 - 5'd10) : 4'(hour_12);
    assign o_pm          = (hour_bin >= 5'd12);

endmodule

// File: tb/tb_bcd_rtc_timer.sv
// Self-checking bench: two clocks (CLK_DIV=1 and CLK_DIV=4) on shared stimulus, checked every cycle.
// Latency: expected results are queued before each edge and popped one cycle-edge later.
// Backpressure: not applicable.
module tb_bcd_rtc_timer;

    typedef struct packed {
        logic [23:0] tm;
        logic [3:0]  dh;
        logic [3:0]  dl;
        logic        pm;
        logic        tick;
        logic        err;
        logic        alarm;
    } obs_t;

    typedef struct {
        logic [23:0] t;
        logic        ok;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        load;
    logic        load_ok;
    logic [23:0] load_time;
    logic        alarm_en;
    logic [15:0] alarm_time;

    logic [3:0] u1_hh, u1_hl, u1_mh, u1_ml, u1_sh, u1_sl, u1_dh, u1_dl;
    logic       u1_pm, u1_tick, u1_err, u1_alarm;
    logic [3:0] u4_hh, u4_hl, u4_mh, u4_ml, u4_sh, u4_sl, u4_dh, u4_dl;
    logic       u4_pm, u4_tick, u4_err, u4_alarm;

    obs_t act1;
    obs_t act4;
    assign act1 = {u1_hh, u1_hl, u1_mh, u1_ml, u1_sh, u1_sl, u1_dh, u1_dl,
                   u1_pm, u1_tick, u1_err, u1_alarm};
    assign act4 = {u4_hh, u4_hl, u4_mh, u4_ml, u4_sh, u4_sl, u4_dh, u4_dl,
                   u4_pm, u4_tick, u4_err, u4_alarm};

    bcd_rtc_timer #(.CLK_DIV(1), .ALARM_EN(1'b1)) dut1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_run(run), .i_load(load),
        .i_load_time(load_time), .i_alarm_en(alarm_en), .i_alarm_time(alarm_time),
        .o_hour_h(u1_hh), .o_hour_l(u1_hl), .o_minute_h(u1_mh), .o_minute_l(u1_ml),
        .o_second_h(u1_sh), .o_second_l(u1_sl), .o_disp_hour_h(u1_dh), .o_disp_hour_l(u1_dl),
        .o_pm(u1_pm), .o_sec_tick(u1_tick), .o_load_err(u1_err), .o_alarm(u1_alarm)
    );

    bcd_rtc_timer #(.CLK_DIV(4), .ALARM_EN(1'b1)) dut4 (
        .i_clk(clk), .i_reset_n(reset_n), .i_run(run), .i_load(load),
        .i_load_time(load_time), .i_alarm_en(alarm_en), .i_alarm_time(alarm_time),
        .o_hour_h(u4_hh), .o_hour_l(u4_hl), .o_minute_h(u4_mh), .o_minute_l(u4_ml),
        .o_second_h(u4_sh), .o_second_l(u4_sl), .o_disp_hour_h(u4_dh), .o_disp_hour_l(u4_dl),
        .o_pm(u4_pm), .o_sec_tick(u4_tick), .o_load_err(u4_err), .o_alarm(u4_alarm)
    );

    always #5 clk = ~clk;

    int    vectors;
    int    fails;
    int    cyc;
    string phase;
    obs_t  q1[$];
    obs_t  q4[$];
    obs_t  rst_obs;
    vec_t  tbl[13];

    // Reference model state per DUT (index 0: CLK_DIV=1, index 1: CLK_DIV=4).
    int mh[2], mm[2], ms[2], mp[2], mdiv[2];

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic obs_t mk_obs(input int d, input logic tk, input logic er, input logic al);
        obs_t e;
        int   hv;
        hv      = (mh[d] == 0) ? 12 : ((mh[d] > 12) ? mh[d] - 12 : mh[d]);
        e.tm    = {bcd2(mh[d]), bcd2(mm[d]), bcd2(ms[d])};
        e.dh    = 4'(hv / 10);
        e.dl    = 4'(hv % 10);
        e.pm    = (mh[d] >= 12);
        e.tick  = tk;
        e.err   = er;
        e.alarm = al;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [35:0] act, input logic [35:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mh[d] = 0; mm[d] = 0; ms[d] = 0; mp[d] = 0;
        end
        q1.delete();
        q4.delete();
    endtask

    // Predict the outputs after the coming edge from the current inputs.
    task automatic model_edge(input int d);
        logic tk, e_tick, e_err, e_alarm;
        tk      = run && (mp[d] == mdiv[d] - 1);
        e_tick  = 1'b0;
        e_alarm = 1'b0;
        e_err   = load && !load_ok;
        if (load && load_ok) begin
            mh[d] = load_time[23:20] * 10 + load_time[19:16];
            mm[d] = load_time[15:12] * 10 + load_time[11:8];
            ms[d] = load_time[7:4] * 10 + load_time[3:0];
            mp[d] = 0;
        end else if (tk) begin
            mp[d] = 0;
            e_tick = 1'b1;
            ms[d]++;
            if (ms[d] == 60) begin
                ms[d] = 0;
                mm[d]++;
                if (mm[d] == 60) begin
                    mm[d] = 0;
                    mh[d]++;
                    if (mh[d] == 24) mh[d] = 0;
                end
            end
            if (ms[d] == 0 && alarm_en && alarm_time == {bcd2(mh[d]), bcd2(mm[d])})
                e_alarm = 1'b1;
        end else if (run) begin
            mp[d]++;
        end
        if (d == 0) q1.push_back(mk_obs(d, e_tick, e_err, e_alarm));
        else        q4.push_back(mk_obs(d, e_tick, e_err, e_alarm));
    endtask

    task automatic check_pop();
        obs_t e;
        if (q1.size() == 0) begin
            vectors++; fails++;
            $display("FAIL %s/div1 cyc%0d: scoreboard empty, got %h", phase, cyc, act1);
        end else begin
            e = q1.pop_front();
            cmp($sformatf("%s/div1 cyc%0d", phase, cyc), act1, e);
        end
        if (q4.size() == 0) begin
            vectors++; fails++;
            $display("FAIL %s/div4 cyc%0d: scoreboard empty, got %h", phase, cyc, act4);
        end else begin
            e = q4.pop_front();
            cmp($sformatf("%s/div4 cyc%0d", phase, cyc), act4, e);
        end
    endtask

    task automatic cycle();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        cyc++;
        check_pop();
    endtask

    task automatic do_load(input logic [23:0] t, input logic ok);
        load_time = t;
        load_ok   = ok;
        load      = 1'b1;
        cycle();
        load      = 1'b0;
        load_ok   = 1'b0;
    endtask

    initial begin
        int n1, n4;
        vectors = 0; fails = 0; cyc = 0;
        clk = 1'b0; reset_n = 1'b0; run = 1'b0; load = 1'b0; load_ok = 1'b0;
        load_time = '0; alarm_en = 1'b0; alarm_time = '0;
        mdiv[0] = 1; mdiv[1] = 4;
        rst_obs = '0; rst_obs.dh = 4'd1; rst_obs.dl = 4'd2;

        tbl[0]  = '{24'h134509, 1'b1};
        tbl[1]  = '{24'h240000, 1'b0};
        tbl[2]  = '{24'h126000, 1'b0};
        tbl[3]  = '{24'h120A00, 1'b0};
        tbl[4]  = '{24'h120000, 1'b1};
        tbl[5]  = '{24'h000000, 1'b1};
        tbl[6]  = '{24'h115959, 1'b1};
        tbl[7]  = '{24'h235960, 1'b0};
        tbl[8]  = '{24'h1A0000, 1'b0};
        tbl[9]  = '{24'h205959, 1'b1};
        tbl[10] = '{24'h095900, 1'b1};
        tbl[11] = '{24'h300000, 1'b0};
        tbl[12] = '{24'h0F0000, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_div1", act1, rst_obs);
        cmp("reset_div4", act4, rst_obs);
        @(negedge clk);
        reset_n = 1'b1;

        // Free run from reset: div4 advances every fourth edge.
        phase = "freerun";
        run = 1'b1;
        repeat (12) cycle();
        cmp("freerun_div4_sec3", {32'd0, u4_sl}, 36'd3);

        // Load table while paused: legal values taken, illegal ones pulse load_err.
        phase = "loadtbl";
        run = 1'b0;
        for (int i = 0; i < 13; i++) begin
            do_load(tbl[i].t, tbl[i].ok);
            cycle();
        end

        // Rollover 23:59:58 -> 23:59:59 -> 00:00:00.
        phase = "rollover";
        do_load(24'h235958, 1'b1);
        run = 1'b1;
        cycle();
        cycle();
        run = 1'b0;
        cycle();

        // Load on the div4 tick cycle discards the tick and restarts the prescaler.
        phase = "load_vs_tick";
        run = 1'b1;
        do_load(24'h010203, 1'b1);
        repeat (3) cycle();
        do_load(24'h102030, 1'b1);
        cmp("load_vs_tick_div4_time", {12'd0, u4_hh, u4_hl, u4_mh, u4_ml, u4_sh, u4_sl},
            36'h000102030);
        repeat (8) cycle();

        // Alarm on tick into 07:30:00.
        phase = "alarm";
        run = 1'b0;
        alarm_time = 16'h0730;
        alarm_en = 1'b1;
        do_load(24'h072959, 1'b1);
        run = 1'b1;
        n1 = 0; n4 = 0;
        repeat (6) begin
            cycle();
            if (u1_alarm) n1++;
            if (u4_alarm) n4++;
        end
        cmp("alarm_count_div1", 36'(n1), 36'd1);
        cmp("alarm_count_div4", 36'(n4), 36'd1);

        // Loading the alarm time directly must not raise it.
        phase = "alarm_load";
        run = 1'b0;
        do_load(24'h073000, 1'b1);
        repeat (2) cycle();

        // Disarmed alarm stays quiet.
        phase = "alarm_off";
        alarm_en = 1'b0;
        do_load(24'h072959, 1'b1);
        run = 1'b1;
        n1 = 0; n4 = 0;
        repeat (6) begin
            cycle();
            if (u1_alarm) n1++;
            if (u4_alarm) n4++;
        end
        cmp("alarm_off_count", 36'(n1 + n4), 36'd0);

        // Pause mid-count: time and prescaler hold, then resume.
        phase = "pause";
        repeat (2) cycle();
        run = 1'b0;
        repeat (20) cycle();
        run = 1'b1;
        repeat (6) cycle();

        // Asynchronous reset between edges clears time and pending pulses at once.
        phase = "async_reset";
        #2;
        reset_n = 1'b0;
        #1;
        cmp("async_reset_div1", act1, rst_obs);
        cmp("async_reset_div4", act4, rst_obs);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        phase = "post_reset";
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
